// File: rtl/mem_dma_engine.sv
// Word-copy DMA initiator sharing the data-memory port through a bus_req/bus_gnt arbiter.
// Optional block-fill mode is compiled in when DMA_FILL_EN is defined.
module mem_dma_engine #(
  parameter int LEN_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic                 MemRd,
  output logic                 MemWr,
  output logic [31:0]          Addr,
  output logic [31:0]          WrData,
  input  logic [31:0]          RdData,
  output logic                 busy,
  output logic                 done
`ifdef DMA_FILL_EN
  ,
  input  logic                 fill_mode,
  input  logic [31:0]          fill_value
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            cur_src;
  logic [31:0]            cur_dst;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [31:0]            buffer;
  logic                   fill_q;
  logic [31:0]            fill_val_q;

`ifdef DMA_FILL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q     <= fill_mode;
      fill_val_q <= fill_value;
    end
  end
`else
  assign fill_q     = 1'b0;
  assign fill_val_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      buffer    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= {src_addr[31:2], 2'b00};
            cur_dst   <= {dst_addr[31:2], 2'b00};
            remaining <= len;
          end
        end
        READ: begin
          buffer  <= RdData;
          cur_src <= cur_src + 32'd4;
        end
        WRITE: begin
          cur_dst   <= cur_dst + 32'd4;
          remaining <= remaining - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Grant is re-sampled at every word boundary; a word already read is always written.
  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    Addr      = '0;
    WrData    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_nxt = fill_q ? WRITE : READ;
      end
      READ: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        MemRd     = 1'b1;
        Addr      = cur_src;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        MemWr   = 1'b1;
        Addr    = cur_dst;
        WrData  = fill_q ? fill_val_q : buffer;
        if (remaining == LEN_WIDTH'(1)) state_nxt = DONE;
        else if (bus_gnt)               state_nxt = fill_q ? WRITE : READ;
        else                            state_nxt = REQ;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine with a 512-word RAM plus digit register model.
// Fill-mode vectors are included when DMA_FILL_EN is defined.
module tb_mem_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [8:0]  len;
  logic        bus_req;
  logic        bus_gnt;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        busy;
  logic        done;
  logic        fill_mode;
  logic [31:0] fill_value;

  logic [31:0] ram [0:511];
  logic [31:0] digi;
  logic        ram_init;
  logic        mon_clr;

  int rd_cnt, wr_cnt, alt_err, viol_cnt, last_kind;
  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_dma_engine #(.LEN_WIDTH(9)) dut (
`ifdef DMA_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .Addr     (Addr),
    .WrData   (WrData),
    .RdData   (RdData),
    .busy     (busy),
    .done     (done)
  );

  // Memory: combinational read, posedge write, digit register at 0x40000010
  assign RdData = (Addr < 32'h800) ? ram[Addr[10:2]] : 32'h0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h1000_0000 | i;
      ram[1] <= 32'h0000_01a8;
      digi   <= 32'h0;
    end else if (MemWr) begin
      if (Addr == 32'h4000_0010) digi <= WrData;
      else if (Addr < 32'h800)   ram[Addr[10:2]] <= WrData;
    end
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_cnt = 0; wr_cnt = 0; alt_err = 0; viol_cnt = 0; last_kind = 0;
    end else begin
      if (MemRd && MemWr) viol_cnt++;
      if (!MemRd && !MemWr && (Addr != 32'h0 || WrData != 32'h0)) viol_cnt++;
      if (MemRd) begin
        rd_cnt++;
        if (last_kind == 1) alt_err++;
        last_kind = 1;
      end
      if (MemWr) begin
        wr_cnt++;
        if (last_kind == 2) alt_err++;
        last_kind = 2;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!done && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [8:0] l);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int n;
    int acc;
    int acc2;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    bus_gnt = 1'b1; fill_mode = 1'b0; fill_value = '0;
    ram_init = 1'b1; mon_clr = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", {27'd0, bus_req, MemRd, MemWr, busy, done}, 32'h0);
    chk("rst_addr", Addr, 32'h0);
    chk("rst_wrdata", WrData, 32'h0);
    rst = 1'b0; ram_init = 1'b0; mon_clr = 1'b0;
    step();

    // Copy 4 words 0x0 -> 0x100 with grant held
    clear_mon();
    kick(32'h0, 32'h100, 9'd4);
    chk("req_state", {29'd0, bus_req, MemRd, MemWr}, 32'h4);
    chk("req_busy", {31'd0, busy}, 32'h1);
    step();
    chk("read1_strobe", {30'd0, MemRd, MemWr}, 32'h2);
    chk("read1_addr", Addr, 32'h0);
    step();
    chk("write1_strobe", {30'd0, MemRd, MemWr}, 32'h1);
    chk("write1_addr", Addr, 32'h100);
    chk("write1_data", WrData, 32'h1000_0000);
    wait_done(20, n);
    chk("copy_latency", 32'(n + 3), 32'd10);
    chk("copy_done", {31'd0, done}, 32'h1);
    chk("done_no_req", {31'd0, bus_req}, 32'h0);
    step();
    chk("done_pulse", {30'd0, done, busy}, 32'h0);
    chk("copy_ram64", ram[64], 32'h1000_0000);
    chk("copy_ram65", ram[65], 32'h0000_01a8);
    chk("copy_ram66", ram[66], 32'h1000_0002);
    chk("copy_ram67", ram[67], 32'h1000_0003);
    chk("copy_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("copy_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("copy_alt", 32'(alt_err), 32'd0);

    // len = 0: done without any bus activity, busy for one cycle
    clear_mon();
    src_addr = 32'h0; dst_addr = 32'h180; len = 9'd0; start = 1'b1;
    acc = 0; acc2 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      acc  += int'(done);
      acc2 += int'(busy);
    end
    chk("len0_done_cnt", 32'(acc), 32'd1);
    chk("len0_busy_cyc", 32'(acc2), 32'd1);
    chk("len0_strobes", 32'(rd_cnt + wr_cnt), 32'd0);

    // Grant dropped for 5 cycles after the first READ
    clear_mon();
    bus_gnt = 1'b1;
    kick(32'h20, 32'h200, 9'd3);
    step();
    chk("gnt_read1", {30'd0, MemRd, MemWr}, 32'h2);
    bus_gnt = 1'b0;
    step();
    chk("gnt_write1", {30'd0, MemRd, MemWr}, 32'h1);
    chk("gnt_write1_data", WrData, 32'h1000_0008);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (MemRd || MemWr || !bus_req || !busy) acc++;
    end
    chk("gnt_park", 32'(acc), 32'd0);
    chk("gnt_park_wr", 32'(wr_cnt), 32'd1);
    bus_gnt = 1'b1;
    wait_done(20, n);
    chk("gnt_done", {31'd0, done}, 32'h1);
    step();
    chk("gnt_ram128", ram[128], 32'h1000_0008);
    chk("gnt_ram129", ram[129], 32'h1000_0009);
    chk("gnt_ram130", ram[130], 32'h1000_000a);
    chk("gnt_alt", 32'(alt_err), 32'd0);

    // Digit register write (src low bits forced to zero)
    kick(32'h7, 32'h4000_0010, 9'd1);
    wait_done(10, n);
    step();
    chk("digit_reg", digi, 32'h0000_01a8);

    // Reset during the 3rd word's READ of an 8-word copy
    clear_mon();
    kick(32'h0, 32'h300, 9'd8);
    repeat (5) step();
    chk("abort_read3", {30'd0, MemRd, MemWr}, 32'h2);
    chk("abort_addr", Addr, 32'h8);
    rst = 1'b1;
    step();
    chk("abort_ctrl", {27'd0, bus_req, MemRd, MemWr, busy, done}, 32'h0);
    chk("abort_bus", Addr | WrData, 32'h0);
    rst = 1'b0;
    step();
    chk("abort_ram192", ram[192], 32'h1000_0000);
    chk("abort_ram193", ram[193], 32'h0000_01a8);
    chk("abort_ram194", ram[194], 32'h1000_00c2);
    kick(32'h8, 32'h380, 9'd2);
    wait_done(20, n);
    chk("restart_latency", 32'(n + 1), 32'd6);
    step();
    chk("restart_ram224", ram[224], 32'h1000_0002);
    chk("restart_ram225", ram[225], 32'h1000_0003);
    chk("bus_viol", 32'(viol_cnt), 32'd0);

`ifdef DMA_FILL_EN
    // Fill mode: 1 cycle/word, no reads
    clear_mon();
    fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
    kick(32'h0, 32'h20, 9'd3);
    fill_mode = 1'b0; fill_value = 32'h0;
    wait_done(20, n);
    chk("fill_latency", 32'(n + 1), 32'd5);
    step();
    chk("fill_ram8", ram[8], 32'hDEAD_BEEF);
    chk("fill_ram9", ram[9], 32'hDEAD_BEEF);
    chk("fill_ram10", ram[10], 32'hDEAD_BEEF);
    chk("fill_no_rd", 32'(rd_cnt), 32'd0);
    chk("fill_wr_cnt", 32'(wr_cnt), 32'd3);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
